// File: rtl/maxnet_scheduler.sv
// Maxnet winner-take-all sequencer: time-multiplexes one 4-input weighted-sum
// unit (PLU) over four neurons per iteration, applies a sign-bit ReLU, and
// stops when at most one neuron survives or the iteration cap is reached.
module maxnet_scheduler #(
    parameter logic [31:0] SELF_W   = 32'h3F800000,
    parameter int unsigned MAX_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_in1,
    input  logic [31:0] a_in2,
    input  logic [31:0] a_in3,
    input  logic [31:0] a_in4,
    input  logic [31:0] eps_w,
    output logic        plu_start,
    output logic [31:0] plu_w1,
    output logic [31:0] plu_w2,
    output logic [31:0] plu_w3,
    output logic [31:0] plu_w4,
    output logic [31:0] plu_a1,
    output logic [31:0] plu_a2,
    output logic [31:0] plu_a3,
    output logic [31:0] plu_a4,
    input  logic        plu_done,
    input  logic [31:0] plu_out,
    input  logic        plu_overflow,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic        winner_valid,
    output logic        timeout,
    output logic        overflow,
    output logic [7:0]  iter_count,
    output logic [31:0] act1,
    output logic [31:0] act2,
    output logic [31:0] act3,
    output logic [31:0] act4
);

    localparam logic [7:0] MAX_ITER_8 = 8'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [3:0][31:0]  act_q, act_d;      // activations driven to the PLU
    logic [3:0][31:0]  nxt_q, nxt_d;      // next-iteration activations being built
    logic [31:0]       eps_q, eps_d;
    logic [1:0]        j_q, j_d;          // neuron whose job is in flight
    logic [31:0]       res_q, res_d;      // PLU result captured with plu_done
    logic              res_ovf_q, res_ovf_d;
    logic              busy_q, busy_d;
    logic [1:0]        winner_q, winner_d;
    logic              winner_valid_q, winner_valid_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        iter_q, iter_d;

    logic [2:0]        alive_cnt;
    logic [1:0]        alive_idx;
    logic              op_en;

    // Count survivors of the finished iteration; magnitude bits only so -0.0 is dead.
    always_comb begin
        alive_cnt = '0;
        alive_idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (nxt_q[k][30:0] != 31'd0) begin
                alive_cnt = alive_cnt + 3'd1;
                alive_idx = 2'(k);
            end
        end
    end

    // Next-state and datapath updates for the job sequencer.
    always_comb begin
        // NOTE: every variable gets a hold-value default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d        = state_q;
        act_d          = act_q;
        nxt_d          = nxt_q;
        eps_d          = eps_q;
        j_d            = j_q;
        res_d          = res_q;
        res_ovf_d      = res_ovf_q;
        busy_d         = busy_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        timeout_d      = timeout_q;
        overflow_d     = overflow_q;
        iter_d         = iter_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    winner_d       = '0;
                    winner_valid_d = 1'b0;
                    timeout_d      = 1'b0;
                    overflow_d     = 1'b0;
                    iter_d         = '0;
                    busy_d         = 1'b1;
                    state_d        = S_LOAD;
                end
            end
            S_LOAD: begin
                act_d   = {a_in4, a_in3, a_in2, a_in1};
                eps_d   = eps_w;
                j_d     = 2'd0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The PLU only guarantees its result in the plu_done cycle.
                if (plu_done) begin
                    res_d     = plu_out;
                    res_ovf_d = plu_overflow;
                    state_d   = S_STORE;
                end
            end
            S_STORE: begin
                nxt_d[j_q] = res_q[31] ? 32'd0 : res_q;
                overflow_d = overflow_q | res_ovf_q;
                if (j_q == 2'd3) begin
                    state_d = S_CHECK;
                end else begin
                    j_d     = j_q + 2'd1;
                    state_d = S_ISSUE;
                end
            end
            S_CHECK: begin
                iter_d = iter_q + 8'd1;
                act_d  = nxt_q;
                j_d    = 2'd0;
                if (alive_cnt == 3'd1) begin
                    winner_d       = alive_idx;
                    winner_valid_d = 1'b1;
                    state_d        = S_FINISH;
                end else if (alive_cnt == 3'd0) begin
                    state_d = S_FINISH;
                end else if (iter_q + 8'd1 == MAX_ITER_8) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            act_q          <= '0;
            nxt_q          <= '0;
            eps_q          <= '0;
            j_q            <= '0;
            res_q          <= '0;
            res_ovf_q      <= 1'b0;
            busy_q         <= 1'b0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            overflow_q     <= 1'b0;
            iter_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q        <= state_d;
            act_q          <= act_d;
            nxt_q          <= nxt_d;
            eps_q          <= eps_d;
            j_q            <= j_d;
            res_q          <= res_d;
            res_ovf_q      <= res_ovf_d;
            busy_q         <= busy_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
            timeout_q      <= timeout_d;
            overflow_q     <= overflow_d;
            iter_q         <= iter_d;
        end
    end

    // Operands are live only while a job is launched or outstanding; act_q,
    // eps_q and j_q cannot change in ISSUE/WAIT, so they stay stable until plu_done.
    assign op_en     = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign plu_start = (state_q == S_ISSUE);

    assign plu_a1 = op_en ? act_q[0] : 32'd0;
    assign plu_a2 = op_en ? act_q[1] : 32'd0;
    assign plu_a3 = op_en ? act_q[2] : 32'd0;
    assign plu_a4 = op_en ? act_q[3] : 32'd0;

    assign plu_w1 = !op_en ? 32'd0 : (j_q == 2'd0) ? SELF_W : eps_q;
    assign plu_w2 = !op_en ? 32'd0 : (j_q == 2'd1) ? SELF_W : eps_q;
    assign plu_w3 = !op_en ? 32'd0 : (j_q == 2'd2) ? SELF_W : eps_q;
    assign plu_w4 = !op_en ? 32'd0 : (j_q == 2'd3) ? SELF_W : eps_q;

    assign done         = (state_q == S_FINISH);
    assign busy         = busy_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;
    assign timeout      = timeout_q;
    assign overflow     = overflow_q;
    assign iter_count   = iter_q;
    assign act1         = act_q[0];
    assign act2         = act_q[1];
    assign act3         = act_q[2];
    assign act4         = act_q[3];

endmodule

// File: tb/tb_maxnet_scheduler.sv
// Bench for maxnet_scheduler: two instances (iteration caps 32 and 4) each
// driving a Q8 integer PLU model with latency 3; a scoreboard compares every
// done pulse against expectations from an iteration-level reference model.
module tb_maxnet_scheduler;

    typedef struct packed {
        logic [1:0]   winner;
        logic         valid;
        logic         timeout;
        logic         ovf;
        logic [7:0]   iter;
        logic [127:0] act;   // {act1, act2, act3, act4}
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] a_in1, a_in2, a_in3, a_in4, eps_w;

    logic        start_v[2], plu_start_v[2], plu_done_r[2], plu_done_in[2];
    logic        stray_v[2], plu_ovf_r[2], busy_v[2], done_v[2];
    logic        wv_v[2], to_v[2], ovf_v[2], prev_ps[2];
    logic [31:0] pw1_v[2], pw2_v[2], pw3_v[2], pw4_v[2];
    logic [31:0] pa1_v[2], pa2_v[2], pa3_v[2], pa4_v[2];
    logic [31:0] plu_out_r[2], res_pipe[2];
    logic [31:0] act1_v[2], act2_v[2], act3_v[2], act4_v[2];
    logic [1:0]  winner_v[2], pv[2];
    logic [7:0]  iter_v[2];
    logic [255:0] cap_ops[2];
    int          job_cnt[2], job_id[2], ovf_job_v[2];

    exp_t exp0[$];
    exp_t exp1[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign plu_done_in[g] = plu_done_r[g] | stray_v[g];
        maxnet_scheduler #(
            .SELF_W   (32'd256),
            .MAX_ITER ((g == 0) ? 32 : 4)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start_v[g]),
            .a_in1        (a_in1),
            .a_in2        (a_in2),
            .a_in3        (a_in3),
            .a_in4        (a_in4),
            .eps_w        (eps_w),
            .plu_start    (plu_start_v[g]),
            .plu_w1       (pw1_v[g]),
            .plu_w2       (pw2_v[g]),
            .plu_w3       (pw3_v[g]),
            .plu_w4       (pw4_v[g]),
            .plu_a1       (pa1_v[g]),
            .plu_a2       (pa2_v[g]),
            .plu_a3       (pa3_v[g]),
            .plu_a4       (pa4_v[g]),
            .plu_done     (plu_done_in[g]),
            .plu_out      (plu_out_r[g]),
            .plu_overflow (plu_ovf_r[g]),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .winner       (winner_v[g]),
            .winner_valid (wv_v[g]),
            .timeout      (to_v[g]),
            .overflow     (ovf_v[g]),
            .iter_count   (iter_v[g]),
            .act1         (act1_v[g]),
            .act2         (act2_v[g]),
            .act3         (act3_v[g]),
            .act4         (act4_v[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [255:0] ops(input int i);
        return {pw1_v[i], pw2_v[i], pw3_v[i], pw4_v[i], pa1_v[i], pa2_v[i], pa3_v[i], pa4_v[i]};
    endfunction

    function automatic logic [31:0] plu_calc(input int i);
        longint s;
        s = longint'(signed'(pw1_v[i])) * longint'(signed'(pa1_v[i]))
          + longint'(signed'(pw2_v[i])) * longint'(signed'(pa2_v[i]))
          + longint'(signed'(pw3_v[i])) * longint'(signed'(pa3_v[i]))
          + longint'(signed'(pw4_v[i])) * longint'(signed'(pa4_v[i]));
        return 32'(s >>> 8);
    endfunction

    function automatic exp_t mk_exp(input int w, input int v, input int t, input int o, input int it,
                                    input int a0, input int a1, input int a2, input int a3);
        exp_t r;
        r.winner  = 2'(w);
        r.valid   = 1'(v);
        r.timeout = 1'(t);
        r.ovf     = 1'(o);
        r.iter    = 8'(it);
        r.act     = {32'(a0), 32'(a1), 32'(a2), 32'(a3)};
        return r;
    endfunction

    // Iteration-level reference: Q8 Maxnet with ReLU, stopping rules, cap.
    function automatic exp_t ref_model(input int a0, input int a1, input int a2, input int a3,
                                       input int eps, input int max_iter, input int ovf_job);
        int     cur[4];
        int     nx[4];
        longint s;
        int     alive, idx, it;
        bit     fin;
        exp_t   r;
        cur = '{a0, a1, a2, a3};
        nx  = '{0, 0, 0, 0};
        r   = '0;
        it  = 0;
        fin = 1'b0;
        while (!fin) begin
            it++;
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += longint'((k == j) ? 256 : eps) * longint'(cur[k]);
                nx[j] = int'(s >>> 8);
                if (nx[j] < 0) nx[j] = 0;
            end
            alive = 0;
            idx   = 0;
            for (int j = 0; j < 4; j++) if (nx[j] != 0) begin alive++; idx = j; end
            if (alive == 1) begin r.winner = 2'(idx); r.valid = 1'b1; fin = 1'b1; end
            else if (alive == 0) fin = 1'b1;
            else if (it == max_iter) begin r.timeout = 1'b1; fin = 1'b1; end
            cur = nx;
        end
        r.iter = 8'(it);
        r.ovf  = (ovf_job >= 0) && (ovf_job < 4 * it);
        r.act  = {32'(nx[0]), 32'(nx[1]), 32'(nx[2]), 32'(nx[3])};
        return r;
    endfunction

    // PLU model per instance: result appears with plu_done three cycles after plu_start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                pv[i] <= '0; res_pipe[i] <= '0; plu_out_r[i] <= '0; plu_done_r[i] <= 1'b0;
                plu_ovf_r[i] <= 1'b0; job_cnt[i] <= 0; job_id[i] <= 0; cap_ops[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                pv[i]         <= {pv[i][0], plu_start_v[i]};
                plu_done_r[i] <= pv[i][1];
                plu_ovf_r[i]  <= pv[i][1] && (job_id[i] == ovf_job_v[i]);
                if (pv[i][1]) plu_out_r[i] <= res_pipe[i];
                if (plu_start_v[i]) begin
                    res_pipe[i] <= plu_calc(i);
                    cap_ops[i]  <= ops(i);
                    job_id[i]   <= job_cnt[i];
                    job_cnt[i]  <= job_cnt[i] + 1;
                end else if (start_v[i] && !busy_v[i]) begin
                    job_cnt[i] <= 0;
                end
            end
        end
    end

    // Monitor: protocol checks plus scoreboard pop on every done pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                if (plu_start_v[i]) check("plu_start_single_cycle", 256'(prev_ps[i]), 256'd0);
                if (plu_done_r[i]) check("plu_operands_stable", ops(i), cap_ops[i]);
                if (done_v[i]) begin
                    if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
                        check("unexpected_done", 256'(done_v[i]), 256'd0);
                    end else begin
                        if (i == 0) mon_e = exp0.pop_front();
                        else        mon_e = exp1.pop_front();
                        check("winner",       256'(winner_v[i]), 256'(mon_e.winner));
                        check("winner_valid", 256'(wv_v[i]),     256'(mon_e.valid));
                        check("timeout",      256'(to_v[i]),     256'(mon_e.timeout));
                        check("overflow",     256'(ovf_v[i]),    256'(mon_e.ovf));
                        check("iter_count",   256'(iter_v[i]),   256'(mon_e.iter));
                        check("act", 256'({act1_v[i], act2_v[i], act3_v[i], act4_v[i]}), 256'(mon_e.act));
                    end
                end
            end
            prev_ps[i] <= rst ? plu_start_v[i] : 1'b0;
        end
    end

    task automatic check_zero(input int i);
        check("rst_status", 256'({busy_v[i], done_v[i], winner_v[i], wv_v[i], to_v[i], ovf_v[i], iter_v[i]}), 256'd0);
        check("rst_act", 256'({act1_v[i], act2_v[i], act3_v[i], act4_v[i]}), 256'd0);
        check("rst_plu_ops", ops(i), 256'd0);
        check("rst_plu_start", 256'(plu_start_v[i]), 256'd0);
    endtask

    task automatic run(input int inst, input int a0, input int a1, input int a2, input int a3,
                       input int eps, input int ovf_job, input bit poke, input exp_t e);
        int cyc;
        @(negedge clk);
        a_in1 = a0; a_in2 = a1; a_in3 = a2; a_in4 = a3; eps_w = eps;
        ovf_job_v[inst] = ovf_job;
        if (inst == 0) exp0.push_back(e);
        else           exp1.push_back(e);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 8 && busy_v[inst]) begin
                a_in1 = 32'd999; a_in2 = 32'd999; a_in3 = 32'd999; a_in4 = 32'd999;
                start_v[inst] = 1'b1;
                @(negedge clk);
                start_v[inst] = 1'b0;
                a_in1 = a0; a_in2 = a1; a_in3 = a2; a_in4 = a3;
                cyc++;
            end
        end while (busy_v[inst] && cyc < 3000);
        check("run_completes", 256'(busy_v[inst]), 256'd0);
    endtask

    initial begin
        int cyc;
        int inst, r0, r1, r2, r3, eps, oj;
        rst = 1'b0;
        a_in1 = '0; a_in2 = '0; a_in3 = '0; a_in4 = '0; eps_w = '0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; stray_v[i] = 1'b0; ovf_job_v[i] = -1;
        end
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst = 1'b1;
        @(negedge clk);

        // Single nonzero neuron wins after one iteration.
        run(0, 100, 0, 0, 0, -32, -1, 1'b0, mk_exp(0, 1, 0, 0, 1, 100, 0, 0, 0));
        // Winner emerges after five iterations; start pulsed while busy.
        run(0, 100, 60, 40, 20, -32, -1, 1'b1, mk_exp(0, 1, 0, 0, 5, 69, 0, 0, 0));
        // Tie decays to all-zero: floor(7x/8) from 50 reaches 0 in 19 steps.
        run(0, 50, 50, 0, 0, -32, -1, 1'b0, mk_exp(0, 0, 0, 0, 19, 0, 0, 0, 0));
        // Same tie against the 4-iteration cap.
        run(1, 50, 50, 0, 0, -32, -1, 1'b0, mk_exp(0, 0, 1, 0, 4, 28, 28, 0, 0));

        // Stray plu_done while idle, then a run with an overflow on job 6.
        @(negedge clk);
        stray_v[0] = 1'b1;
        @(negedge clk);
        stray_v[0] = 1'b0;
        @(negedge clk);
        check("idle_ignores_plu_done", 256'(busy_v[0]), 256'd0);
        run(0, 100, 60, 40, 20, -32, 6, 1'b0, mk_exp(0, 1, 0, 1, 5, 69, 0, 0, 0));

        // Reset during WAIT of iteration 2 aborts without a done pulse.
        @(negedge clk);
        a_in1 = 100; a_in2 = 60; a_in3 = 40; a_in4 = 20; eps_w = -32;
        ovf_job_v[0] = -1;
        exp0.push_back(mk_exp(0, 1, 0, 0, 5, 69, 0, 0, 0));
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (!(iter_v[0] == 8'd1 && plu_start_v[0]) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("reset_reached_iter2", 256'(iter_v[0]), 256'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_zero(0);
        check_zero(1);
        exp0.delete();
        exp1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("no_restart_after_reset", 256'(busy_v[0]), 256'd0);
        run(0, 100, 60, 40, 20, -32, -1, 1'b0, mk_exp(0, 1, 0, 0, 5, 69, 0, 0, 0));

        // Randomized runs on both instances against the reference model.
        for (int n = 0; n < 40; n++) begin
            inst = int'($urandom_range(0, 1));
            r0 = int'($urandom_range(0, 1500));
            r1 = int'($urandom_range(0, 1500));
            r2 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1500));
            r3 = int'($urandom_range(0, 1500));
            eps = -int'($urandom_range(1, 96));
            oj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            run(inst, r0, r1, r2, r3, eps, oj, ($urandom_range(0, 3) == 0),
                ref_model(r0, r1, r2, r3, eps, (inst == 0) ? 32 : 4, oj));
        end

        repeat (10) @(negedge clk);
        check("pending_expectations", 256'(exp0.size() + exp1.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
